cnn_row_assembler: RTL and testbench

//  Upstream feeder for cnn_layer. Converts the 32-bit pixel stream into full image rows:
//  in_data_i[31:0] words arrive one value per transfer, as on cnn_top's in_data port.

---
 rtl/cnn_row_assembler.sv | 113 +++++++++++
 tb/tb_cnn_row_assembler.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_row_assembler.sv
// Assembles a scalar pixel stream into complete image rows using two ping-pong banks,
// presenting each finished row with its image-row index and last-row tag.
module cnn_row_assembler #(
    parameter int WIDTH       = 28,
    parameter int HEIGHT      = 28,
    parameter int VALUE_BITS  = 8,
    parameter int IN_CHANNELS = 1,
    parameter int DATA_BITS   = 32,
    localparam int IDX_W      = (HEIGHT > 1) ? $clog2(HEIGHT) : 1
) (
    input  logic                                              clock_i,
    input  logic                                              reset_i,
    input  logic [DATA_BITS-1:0]                              in_data_i,
    input  logic                                              in_valid_i,
    output logic                                              upstream_stall_o,
    output logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] out_row_o,
    output logic                                              out_row_valid_o,
    input  logic                                              out_row_ready_i,
    output logic [IDX_W-1:0]                                  out_row_idx_o,
    output logic                                              out_last_row_o
);

    localparam int CHAN_W = (IN_CHANNELS > 1) ? $clog2(IN_CHANNELS) : 1;
    localparam int COL_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] row_t;

    row_t [1:0]            bank_q, bank_d;
    logic [1:0][IDX_W-1:0] idx_q, idx_d;
    logic [1:0]            full_q, full_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  rd_bank_q, rd_bank_d;
    logic [CHAN_W-1:0]     chan_q, chan_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [IDX_W-1:0]      row_q, row_d;

    logic accept, pop, last_chan, last_col, last_row;

    // Only the low VALUE_BITS of each stream word carry data.
    logic unused_upper_bits;
    assign unused_upper_bits = ^in_data_i;

    assign upstream_stall_o = full_q[wr_bank_q];
    assign accept           = in_valid_i && !full_q[wr_bank_q];
    assign pop              = full_q[rd_bank_q] && out_row_ready_i;
    assign last_chan        = (chan_q == CHAN_W'(IN_CHANNELS - 1));
    assign last_col         = (col_q == COL_W'(WIDTH - 1));
    assign last_row         = (row_q == IDX_W'(HEIGHT - 1));

    assign out_row_valid_o = full_q[rd_bank_q];
    assign out_row_o       = bank_q[rd_bank_q];
    assign out_row_idx_o   = idx_q[rd_bank_q];
    assign out_last_row_o  = out_row_valid_o && (out_row_idx_o == IDX_W'(HEIGHT - 1));

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bank_q    <= '0;
            idx_q     <= '0;
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            chan_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
        end else begin
            bank_q    <= bank_d;
            idx_q     <= idx_d;
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            chan_q    <= chan_d;
            col_q     <= col_d;
            row_q     <= row_d;
        end
    end

    // A pop and a row completion in the same cycle always address different banks,
    // so both updates to full_d can be applied independently.
    always_comb begin
        bank_d    = bank_q;
        idx_d     = idx_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        chan_d    = chan_q;
        col_d     = col_q;
        row_d     = row_q;

        if (pop) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
        end

        if (accept) begin
            bank_d[wr_bank_q][col_q][chan_q] = in_data_i[VALUE_BITS-1:0];
            if (!last_chan) begin
                chan_d = chan_q + CHAN_W'(1);
            end else begin
                chan_d = '0;
                if (!last_col) begin
                    col_d = col_q + COL_W'(1);
                end else begin
                    col_d             = '0;
                    full_d[wr_bank_q] = 1'b1;
                    idx_d[wr_bank_q]  = row_q;
                    wr_bank_d         = ~wr_bank_q;
                    row_d             = last_row ? '0 : row_q + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cnn_row_assembler.sv
// Randomized bench for cnn_row_assembler: a queue-of-rows model predicts stall, valid,
// row contents and tags every cycle; literal checks pin the model on key scenarios.
module tb_cnn_row_assembler;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int VB = 8;
    localparam int IC = 1;
    localparam int IW = 5;

    typedef logic [W-1:0][IC-1:0][VB-1:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]   in_data  = '0;
    logic          in_valid = 1'b0;
    logic          ready    = 1'b0;
    logic          stall, valid, last;
    row_t          row;
    logic [IW-1:0] idx;

    logic [31:0]         d2 = '0;
    logic                v2 = 1'b0;
    logic                stall2, valid2, last2;
    logic [3:0][1:0][7:0] row2;
    logic [0:0]          idx2;

    cnn_row_assembler #(.WIDTH(W), .HEIGHT(H), .VALUE_BITS(VB), .IN_CHANNELS(IC), .DATA_BITS(32)) u_dut (
        .clock_i(clk), .reset_i(rst), .in_data_i(in_data), .in_valid_i(in_valid),
        .upstream_stall_o(stall), .out_row_o(row), .out_row_valid_o(valid),
        .out_row_ready_i(ready), .out_row_idx_o(idx), .out_last_row_o(last)
    );

    cnn_row_assembler #(.WIDTH(4), .HEIGHT(2), .VALUE_BITS(8), .IN_CHANNELS(2), .DATA_BITS(32)) u_dut2 (
        .clock_i(clk), .reset_i(rst), .in_data_i(d2), .in_valid_i(v2),
        .upstream_stall_o(stall2), .out_row_o(row2), .out_row_valid_o(valid2),
        .out_row_ready_i(1'b1), .out_row_idx_o(idx2), .out_last_row_o(last2)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: rows held = queue of completed rows; the front row is the one presented.
    row_t mq[$];
    int   mi[$];
    row_t cur;
    int   k    = 0;
    int   mrow = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            mi.delete();
            k    = 0;
            mrow = 0;
        end else begin
            bit p, a;
            p = (mq.size() > 0) && ready;
            a = in_valid && (mq.size() < 2);
            if (p) begin
                void'(mq.pop_front());
                void'(mi.pop_front());
            end
            if (a) begin
                cur[k / IC][k % IC] = in_data[VB-1:0];
                k++;
                if (k == W * IC) begin
                    mq.push_back(cur);
                    mi.push_back(mrow);
                    mrow = (mrow + 1) % H;
                    k    = 0;
                end
            end
        end
    end

    int pops  = 0;
    int lasts = 0;

    always @(negedge clk) begin
        if (!rst) begin
            chk("stall", 64'(stall), 64'(mq.size() == 2));
            chk("valid", 64'(valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                checks++;
                if (row !== mq[0]) begin
                    errors++;
                    $display("FAIL row: got %h expected %h", row, mq[0]);
                end
                chk("idx", 64'(idx), 64'(mi[0]));
                chk("last", 64'(last), 64'(mi[0] == H - 1));
            end
            if (valid && ready) begin
                pops++;
                if (last) lasts++;
            end
        end
    end

    bit rand_ready = 1'b0;
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w);
        int   n = 0;
        logic a = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        do begin
            @(negedge clk);
            a = !stall;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 2000);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got stalled expected accepted");
        end
        in_valid = 1'b0;
    endtask

    task automatic send2(input logic [31:0] w);
        int   n = 0;
        logic a = 1'b0;
        v2 = 1'b1;
        d2 = w;
        do begin
            @(negedge clk);
            a = !stall2;
            @(posedge clk);
            #1;
            n++;
        end while (!a && n < 100);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL send2_timeout: got stalled expected accepted");
        end
        v2 = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle(2);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_row_zero", 64'(row == '0), 64'd1);
        rst = 1'b0;

        // Two-channel, four-column instance
        for (int i = 1; i <= 8; i++) send2(32'(i));
        chk("t6_valid", 64'(valid2), 64'd1);
        chk("t6_row", 64'(row2), 64'h0807060504030201);
        chk("t6_idx", 64'(idx2), 64'd0);

        // Single row with ready high
        ready = 1'b1;
        for (int i = 0; i < 28; i++) send(32'(i));
        chk("t1_valid", 64'(valid), 64'd1);
        chk("t1_idx", 64'(idx), 64'd0);
        chk("t1_first", 64'(row[0][0]), 64'd0);
        chk("t1_lastval", 64'(row[27][0]), 64'd27);
        idle(1);
        chk("t1_drop", 64'(valid), 64'd0);

        // Back-pressure: two rows fill both banks, third row's first word waits
        do_reset();
        ready = 1'b0;
        repeat (56) send($urandom);
        chk("t2_stall", 64'(stall), 64'd1);
        chk("t2_idx", 64'(idx), 64'd0);
        fork
            send(32'h77);
            begin
                idle(6);
                ready = 1'b1;
            end
        join
        idle(5);

        // Upper word bits ignored
        do_reset();
        ready = 1'b1;
        send(32'hFFFF_FF5A);
        repeat (27) send($urandom);
        chk("t3_val", 64'(row[0][0]), 64'h5A);

        // Two full images with ready held
        do_reset();
        ready = 1'b1;
        pops  = 0;
        lasts = 0;
        repeat (56 * 28) send($urandom);
        idle(2);
        chk("t4_rows", 64'(pops), 64'd56);
        chk("t4_lastrows", 64'(lasts), 64'd2);

        // Random gaps and random ready
        do_reset();
        rand_ready = 1'b1;
        repeat (300) begin
            int r;
            send($urandom);
            r = $urandom_range(0, 2);
            if (r > 0) idle(r);
        end
        rand_ready = 1'b0;
        idle(1);
        ready = 1'b1;
        idle(10);

        // Reset mid-row with a full row held
        do_reset();
        ready = 1'b0;
        repeat (41) send($urandom);
        chk("t5_held", 64'(valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_valid_drop", 64'(valid), 64'd0);
        idle(1);
        rst   = 1'b0;
        ready = 1'b1;
        repeat (28) send($urandom);
        chk("t5_valid", 64'(valid), 64'd1);
        chk("t5_idx", 64'(idx), 64'd0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
